apb_req_arbiter: RTL



---
 rtl/apb_arb_pkg.sv | 17 +
 rtl/apb_arb_pick.sv | 28 ++
 rtl/apb_req_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter: FSM state, owner index,
// and the reset value of the round-robin history.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   typedef logic owner_t;

   // Requester 1 counts as the last owner out of reset, so requester 0 wins
   // the first contention.
   localparam owner_t LAST_OWNER_RST = 1'b1;

endpackage

// File: rtl/apb_arb_pick.sv
// Next-owner selection. APB_ARB_ROUND_ROBIN_EN selects round-robin against
// last_owner; without it requester 0 always wins contention.
module apb_arb_pick
   import apb_arb_pkg::*;
(
   input  logic   req0,
   input  logic   req1,
`ifdef APB_ARB_ROUND_ROBIN_EN
   input  owner_t last_owner,
`endif
   output logic   any_req,
   output owner_t owner
);

   always_comb begin
      any_req = req0 | req1;
`ifdef APB_ARB_ROUND_ROBIN_EN
      if (req0 && req1) begin
         owner = ~last_owner;
      end else begin
         owner = req1;
      end
`else
      owner = ~req0;
`endif
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester arbiter in front of the single APB master: serialises
// requests, pulses m_transfer once per grant and routes ready/rdata back to
// the owner. Arbitration policy set by APB_ARB_ROUND_ROBIN_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no owner, grant 00; sample requests and latch the winner
// ST_ISSUE | m_transfer high for one cycle, owner's command on m_*
// ST_WAIT  | hold owner's command until m_ready, then pulse its ready
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              PCLK,
   input  logic              PRESET,

   input  logic              req0_transfer,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic [DATA_W-1:0] req0_rdata,

   input  logic              req1_transfer,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic [DATA_W-1:0] req1_rdata,

   output logic              m_transfer,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ready,
   input  logic [DATA_W-1:0] m_rdata,

   output logic [1:0]        grant
);

   state_e state_q, state_d;
   owner_t owner_q, owner_d;
   owner_t pick_owner;
   logic   any_req;
   logic   busy;
   logic   done;

`ifdef APB_ARB_ROUND_ROBIN_EN
   owner_t last_owner_q, last_owner_d;
`endif

   apb_arb_pick u_pick (
      .req0       (req0_transfer),
      .req1       (req1_transfer),
`ifdef APB_ARB_ROUND_ROBIN_EN
      .last_owner (last_owner_q),
`endif
      .any_req    (any_req),
      .owner      (pick_owner)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
`ifdef APB_ARB_ROUND_ROBIN_EN
         last_owner_q <= LAST_OWNER_RST;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
`ifdef APB_ARB_ROUND_ROBIN_EN
         last_owner_q <= last_owner_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
`ifdef APB_ARB_ROUND_ROBIN_EN
      last_owner_d = last_owner_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_ISSUE;
               owner_d = pick_owner;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (m_ready) begin
               state_d      = ST_IDLE;
`ifdef APB_ARB_ROUND_ROBIN_EN
               last_owner_d = owner_q;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The reset cycle suppresses completion so a reset in WAIT never leaks a
   // ready to the requester being abandoned.
   always_comb begin
      busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
      done       = (state_q == ST_WAIT) && m_ready && !PRESET;
      m_transfer = (state_q == ST_ISSUE);
      grant      = 2'b00;
      m_write    = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      if (busy) begin
         grant   = owner_q ? 2'b10 : 2'b01;
         m_write = owner_q ? req1_write : req0_write;
         m_addr  = owner_q ? req1_addr  : req0_addr;
         m_wdata = owner_q ? req1_wdata : req0_wdata;
      end
      req0_ready = done && !owner_q;
      req1_ready = done && owner_q;
      req0_rdata = req0_ready ? m_rdata : '0;
      req1_rdata = req1_ready ? m_rdata : '0;
   end

endmodule
